// File: rtl/temporal_slice_sequencer_pkg.sv
// Shared state encoding and width/shift helpers for the temporal slice sequencer.
// All helpers are constant functions so they can size ports and parameters.
package temporal_slice_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int min_width(input int aw, input int bw);
        return (aw < bw) ? aw : bw;
    endfunction

    function automatic int shifter_width(input int maxp, input int aw, input int bw);
        return $clog2(2 * maxp - aw - bw + 1) - $clog2(min_width(aw, bw));
    endfunction

    // Number of slices of width sw covering one operand of a maxp-bit product.
    function automatic int max_slices(input int maxp, input int sw);
        return (maxp / 2) / sw;
    endfunction

    function automatic int count_width(input int nmax);
        return $clog2(nmax) + 1;
    endfunction

    // Shift of slice (i, j) in MIN_WIDTH granules.
    function automatic int slice_shift(input int i, input int j, input int aw, input int bw,
                                       input int mw);
        return (i * aw + j * bw) / mw;
    endfunction

endpackage

// File: rtl/temporal_slice_sequencer_slice_index_counter.sv
// Nested slice counter: i (inner) runs 0..na-1, j (outer) runs 0..nb-1.
// Exposes next-state indices so the parent can register slice outputs directly.
module slice_index_counter
    import temporal_slice_sequencer_pkg::*;
#(
    parameter int NAW = count_width(4),
    parameter int NBW = count_width(2)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [NAW-1:0] na_i,
    input  logic [NBW-1:0] nb_i,
    output logic [NAW-1:0] i_nxt_o,
    output logic [NBW-1:0] j_nxt_o,
    output logic           a_top_nxt_o,
    output logic           b_top_nxt_o,
    output logic           last_o
);

    logic [NAW-1:0] i_q, i_d, na_q, na_d;
    logic [NBW-1:0] j_q, j_d, nb_q, nb_d;

    always_comb begin
        i_d  = i_q;
        j_d  = j_q;
        na_d = na_q;
        nb_d = nb_q;
        if (load_i) begin
            i_d  = '0;
            j_d  = '0;
            na_d = na_i;
            nb_d = nb_i;
        end else if (step_i) begin
            if (i_q == na_q - NAW'(1)) begin
                i_d = '0;
                j_d = (j_q == nb_q - NBW'(1)) ? '0 : j_q + NBW'(1);
            end else begin
                i_d = i_q + NAW'(1);
            end
        end
    end

    assign i_nxt_o     = i_d;
    assign j_nxt_o     = j_d;
    assign a_top_nxt_o = (i_d == na_d - NAW'(1));
    assign b_top_nxt_o = (j_d == nb_d - NBW'(1));
    assign last_o      = (i_q == na_q - NAW'(1)) && (j_q == nb_q - NBW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_q  <= '0;
            j_q  <= '0;
            na_q <= NAW'(1);
            nb_q <= NBW'(1);
        end else begin
            i_q  <= i_d;
            j_q  <= j_d;
            na_q <= na_d;
            nb_q <= nb_d;
        end
    end

endmodule

// File: rtl/temporal_slice_sequencer.sv
// Splits full-precision operand pairs into A_WIDTH x B_WIDTH slice products for the
// temporal MAC, one slice per cycle, latency 1, with no bubble between back-to-back pairs.
module temporal_slice_sequencer
    import temporal_slice_sequencer_pkg::*;
#(
    parameter int  A_WIDTH       = 2,
    parameter int  B_WIDTH       = 4,
    parameter int  MAX_PRECISION = 16,
    localparam int OP_WIDTH      = MAX_PRECISION / 2,
    localparam int MIN_WIDTH     = min_width(A_WIDTH, B_WIDTH),
    localparam int SHIFTER_WIDTH = shifter_width(MAX_PRECISION, A_WIDTH, B_WIDTH),
    localparam int NA_MAX        = max_slices(MAX_PRECISION, A_WIDTH),
    localparam int NB_MAX        = max_slices(MAX_PRECISION, B_WIDTH),
    localparam int NAW           = count_width(NA_MAX),
    localparam int NBW           = count_width(NB_MAX)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_WIDTH-1:0]      in_a,
    input  logic [OP_WIDTH-1:0]      in_b,
    input  logic                     in_a_signed,
    input  logic                     in_b_signed,
    input  logic [NAW-1:0]           in_a_nslices,
    input  logic [NBW-1:0]           in_b_nslices,
    input  logic                     in_clear,
    output logic [A_WIDTH-1:0]       a,
    output logic [B_WIDTH-1:0]       b,
    output logic                     a_sign_mode,
    output logic                     b_sign_mode,
    output logic [SHIFTER_WIDTH-1:0] shift,
    output logic                     sel,
    output logic                     slice_valid,
    output logic                     pair_done
);

    state_e state_q, state_d;

    logic [OP_WIDTH-1:0] a_op_q, a_op_d, b_op_q, b_op_d;
    logic                as_q, as_d, bs_q, bs_d, clr_q, clr_d;

    logic [A_WIDTH-1:0]       a_q, a_d;
    logic [B_WIDTH-1:0]       b_q, b_d;
    logic [SHIFTER_WIDTH-1:0] shift_q, shift_d;
    logic                     asm_q, asm_d, bsm_q, bsm_d;
    logic                     sel_q, sel_d, vld_q, vld_d, done_q, done_d, rdy_q, rdy_d;

    logic           accept, step, cnt_last, cur_last;
    logic [NAW-1:0] na_clamp, i_nxt;
    logic [NBW-1:0] nb_clamp, j_nxt;
    logic           a_top_nxt, b_top_nxt;
    logic [OP_WIDTH-1:0] a_sh, b_sh;

    always_comb begin
        na_clamp = in_a_nslices;
        if (in_a_nslices == '0) begin
            na_clamp = NAW'(1);
        end else if (in_a_nslices > NAW'(NA_MAX)) begin
            na_clamp = NAW'(NA_MAX);
        end
        nb_clamp = in_b_nslices;
        if (in_b_nslices == '0) begin
            nb_clamp = NBW'(1);
        end else if (in_b_nslices > NBW'(NB_MAX)) begin
            nb_clamp = NBW'(NB_MAX);
        end
    end

    // in_ready is only high when idle or on the last slice, so an accept never
    // overlaps a mid-pair step.
    assign accept   = in_valid & rdy_q;
    assign cur_last = (state_q == RUN) & cnt_last;
    assign step     = (state_q == RUN) & ~cnt_last & ~accept;

    slice_index_counter #(
        .NAW (NAW),
        .NBW (NBW)
    ) u_slice_index_counter (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (accept),
        .step_i      (step),
        .na_i        (na_clamp),
        .nb_i        (nb_clamp),
        .i_nxt_o     (i_nxt),
        .j_nxt_o     (j_nxt),
        .a_top_nxt_o (a_top_nxt),
        .b_top_nxt_o (b_top_nxt),
        .last_o      (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = RUN;
        end else if (cur_last) begin
            state_d = IDLE;
        end

        a_op_d = accept ? in_a        : a_op_q;
        b_op_d = accept ? in_b        : b_op_q;
        as_d   = accept ? in_a_signed : as_q;
        bs_d   = accept ? in_b_signed : bs_q;
        clr_d  = accept ? in_clear    : clr_q;

        a_sh = a_op_d >> (int'(i_nxt) * A_WIDTH);
        b_sh = b_op_d >> (int'(j_nxt) * B_WIDTH);

        // Idle outputs are all zero so the MAC accumulates nothing.
        a_d     = '0;
        b_d     = '0;
        shift_d = '0;
        asm_d   = 1'b0;
        bsm_d   = 1'b0;
        sel_d   = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        if (state_d == RUN) begin
            a_d     = a_sh[A_WIDTH-1:0];
            b_d     = b_sh[B_WIDTH-1:0];
            shift_d = SHIFTER_WIDTH'(slice_shift(int'(i_nxt), int'(j_nxt),
                                                 A_WIDTH, B_WIDTH, MIN_WIDTH));
            asm_d   = as_d & a_top_nxt;
            bsm_d   = bs_d & b_top_nxt;
            sel_d   = clr_d & (i_nxt == '0) & (j_nxt == '0);
            vld_d   = 1'b1;
            done_d  = a_top_nxt & b_top_nxt;
        end
        rdy_d = (state_d == IDLE) | done_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_op_q  <= '0;
            b_op_q  <= '0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
            clr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            asm_q   <= 1'b0;
            bsm_q   <= 1'b0;
            sel_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            a_op_q  <= a_op_d;
            b_op_q  <= b_op_d;
            as_q    <= as_d;
            bs_q    <= bs_d;
            clr_q   <= clr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            asm_q   <= asm_d;
            bsm_q   <= bsm_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign a           = a_q;
    assign b           = b_q;
    assign shift       = shift_q;
    assign a_sign_mode = asm_q;
    assign b_sign_mode = bsm_q;
    assign sel         = sel_q;
    assign slice_valid = vld_q;
    assign pair_done   = done_q;

endmodule

// File: tb/tb_temporal_slice_sequencer.sv
// Scoreboard bench: expected slices and MAC results are queued at accept time and
// checked as the sequencer emits slices, with a small MAC model rebuilding products.
module tb_temporal_slice_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic       in_a_signed, in_b_signed, in_clear;
    logic [2:0] in_a_nslices;
    logic [1:0] in_b_nslices;
    logic [1:0] a;
    logic [3:0] b;
    logic [3:0] shift;
    logic       a_sign_mode, b_sign_mode, sel, slice_valid, pair_done;

    temporal_slice_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_a_signed  (in_a_signed),
        .in_b_signed  (in_b_signed),
        .in_a_nslices (in_a_nslices),
        .in_b_nslices (in_b_nslices),
        .in_clear     (in_clear),
        .a            (a),
        .b            (b),
        .a_sign_mode  (a_sign_mode),
        .b_sign_mode  (b_sign_mode),
        .shift        (shift),
        .sel          (sel),
        .slice_valid  (slice_valid),
        .pair_done    (pair_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] exp_q[$];
    longint      mac_q[$];
    int          slices_seen = 0;
    longint      acc = 0;
    logic [13:0] got;
    longint      av, bv, prod;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    // Slice record: {a[1:0], b[3:0], shift[3:0], a_sign, b_sign, sel, pair_done}
    always @(negedge clk) begin
        if (reset && slice_valid) begin
            got = {a, b, shift, a_sign_mode, b_sign_mode, sel, pair_done};
            slices_seen++;
            if (exp_q.size() == 0) chk("spurious_slice", 1, 0);
            else chk("slice", got, exp_q.pop_front());
            if (a_sign_mode) av = longint'($signed(a)); else av = longint'(a);
            if (b_sign_mode) bv = longint'($signed(b)); else bv = longint'(b);
            prod = (av * bv) << (2 * int'(shift));
            if (sel) acc = prod; else acc = acc + prod;
            if (pair_done) begin
                if (mac_q.size() == 0) chk("spurious_done", 1, 0);
                else chk("mac", acc, mac_q.pop_front());
            end
        end
    end

    task automatic push_model(input logic [7:0] A, input logic [7:0] B, input logic as,
                              input logic bs, input int na, input int nb, input logic clr);
        int nae, nbe;
        nae = (na == 0) ? 1 : ((na > 4) ? 4 : na);
        nbe = (nb == 0) ? 1 : ((nb > 2) ? 2 : nb);
        for (int j = 0; j < nbe; j++) begin
            for (int i = 0; i < nae; i++) begin
                exp_q.push_back({2'(A >> (2 * i)), 4'(B >> (4 * j)), 4'((2 * i + 4 * j) / 2),
                                 1'(as && (i == nae - 1)), 1'(bs && (j == nbe - 1)),
                                 1'(clr && i == 0 && j == 0),
                                 1'((i == nae - 1) && (j == nbe - 1))});
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [7:0] A, input logic [7:0] B, input logic as, input logic bs,
                        input int na, input int nb, input logic clr, input longint mac,
                        output int waits);
        in_valid     = 1'b1;
        in_a         = A;
        in_b         = B;
        in_a_signed  = as;
        in_b_signed  = bs;
        in_a_nslices = 3'(na);
        in_b_nslices = 2'(nb);
        in_clear     = clr;
        waits = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            push_model(A, B, as, bs, na, nb, clr);
            mac_q.push_back(mac);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mac_q.size() != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", longint'(exp_q.size() + mac_q.size()), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_vld"}, slice_valid, 0);
        chk({tag, "_ab"}, {a, b, shift, sel, a_sign_mode, b_sign_mode, pair_done}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, base, n;
        reset = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_a_signed = 1'b0;
        in_b_signed = 1'b0;
        in_a_nslices = '0;
        in_b_nslices = '0;
        in_clear = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Signed -3 x 5 over 4x2 slices
        send(8'hFD, 8'h05, 1'b1, 1'b1, 4, 2, 1'b1, -15, w);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        #1;
        check_idle("after_signed");

        // Unsigned 255 x 255
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 4, 2, 1'b1, 65025, w);
        in_valid = 1'b0;
        drain();

        // Back-to-back single-slice pairs, second one accumulates
        send(8'h01, 8'h03, 1'b1, 1'b1, 1, 1, 1'b1, 3, w);
        send(8'hFE, 8'h07, 1'b1, 1'b1, 1, 1, 1'b0, -11, w);
        in_valid = 1'b0;
        chk("b2b_waits", w, 0);
        drain();

        // Clamping: na=0 -> 1, nb=3 -> 2
        base = slices_seen;
        send(8'h02, 8'h31, 1'b0, 1'b0, 0, 3, 1'b1, 98, w);
        in_valid = 1'b0;
        drain();
        chk("clamp_count", slices_seen - base, 2);

        // New pair offered mid-pair is held off until the last slice
        send(8'hB4, 8'h09, 1'b0, 1'b0, 4, 1, 1'b1, 1620, w);
        send(8'h1B, 8'h06, 1'b0, 1'b0, 4, 1, 1'b0, 1782, w);
        in_valid = 1'b0;
        chk("midpair_waits", w, 3);
        drain();

        // Reset in the middle of a pair
        base = slices_seen;
        send(8'hFD, 8'h05, 1'b1, 1'b1, 4, 2, 1'b1, -15, w);
        in_valid = 1'b0;
        n = 0;
        while (slices_seen < base + 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_slice3", slices_seen - base, 3);
        #1;
        reset = 1'b0;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        mac_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(8'h07, 8'h0C, 1'b0, 1'b0, 2, 1, 1'b1, 84, w);
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        #1;
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
